// File: rtl/get_stream_len_csum.sv
// Store-and-forward UDP payload stage: buffers each packet, computes byte length and
// one's-complement sum, then replays it with header/len/csum held alongside.
module get_stream_len_csum #(
   parameter int FIFO_SIZE_DATA = 1024,
   parameter int FIFO_SIZE_HDR  = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] hdr_ip_dest_i,
   input  logic [31:0] hdr_ip_src_i,
   input  logic [15:0] hdr_port_dest_i,
   input  logic [15:0] hdr_port_src_i,
   input  logic [31:0] user_tdata_i,
   input  logic        user_tvld_i,
   input  logic        user_tlast_i,
   input  logic [3:0]  user_tkeep_i,
   output logic        user_trdy_o,
   output logic [31:0] hdr_ip_dest_o,
   output logic [31:0] hdr_ip_src_o,
   output logic [15:0] hdr_port_dest_o,
   output logic [15:0] hdr_port_src_o,
   output logic [15:0] user_data_csum_o,
   output logic [15:0] user_data_len_o,
   output logic [31:0] user_tdata_o,
   output logic        user_tvld_o,
   output logic        user_tlast_o,
   output logic [3:0]  user_tkeep_o,
   input  logic        user_trdy_i
);

   localparam int DAW = $clog2(FIFO_SIZE_DATA);
   localparam int DCW = DAW + 1;
   localparam int HAW = $clog2(FIFO_SIZE_HDR);
   localparam int HCW = HAW + 1;

   // ---------------- input side: header latch and accumulators ----------------
   logic        r_trdy;
   logic        r_first;
   logic [31:0] r_ip_dest, r_ip_src;
   logic [15:0] r_port_dest, r_port_src;
   logic [15:0] r_len, r_sum;

   logic        w_in_acc;
   logic        w_hpush;
   logic [2:0]  w_len_beat;
   logic [31:0] w_masked;
   logic [15:0] w_len_nxt, w_sum_base, w_sum_nxt;
   logic [17:0] w_s18;
   logic [16:0] w_s17;
   logic [31:0] w_ipd, w_ips;
   logic [15:0] w_pd, w_ps;
   logic [127:0] w_hentry;

   assign w_in_acc   = user_tvld_i & r_trdy;
   assign w_hpush    = w_in_acc & user_tlast_i;
   assign w_len_beat = 3'(user_tkeep_i[3]) + 3'(user_tkeep_i[2])
                     + 3'(user_tkeep_i[1]) + 3'(user_tkeep_i[0]);
   // masked bytes contribute zero, which also pads an odd-length tail
   assign w_masked   = user_tdata_i & {{8{user_tkeep_i[3]}}, {8{user_tkeep_i[2]}},
                                       {8{user_tkeep_i[1]}}, {8{user_tkeep_i[0]}}};
   assign w_len_nxt  = (r_first ? 16'd0 : r_len) + 16'(w_len_beat);
   assign w_sum_base = r_first ? 16'd0 : r_sum;
   assign w_s18      = 18'(w_sum_base) + 18'(w_masked[31:16]) + 18'(w_masked[15:0]);
   assign w_s17      = 17'(w_s18[15:0]) + 17'(w_s18[17:16]);
   assign w_sum_nxt  = w_s17[15:0] + 16'(w_s17[16]);

   assign w_ipd = r_first ? hdr_ip_dest_i   : r_ip_dest;
   assign w_ips = r_first ? hdr_ip_src_i    : r_ip_src;
   assign w_pd  = r_first ? hdr_port_dest_i : r_port_dest;
   assign w_ps  = r_first ? hdr_port_src_i  : r_port_src;
   assign w_hentry = {w_ipd, w_ips, w_pd, w_ps, w_sum_nxt, w_len_nxt};

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_first     <= 1'b1;
         r_len       <= '0;
         r_sum       <= '0;
         r_ip_dest   <= '0;
         r_ip_src    <= '0;
         r_port_dest <= '0;
         r_port_src  <= '0;
      end else if (w_in_acc) begin
         r_first <= user_tlast_i;
         r_len   <= w_len_nxt;
         r_sum   <= w_sum_nxt;
         if (r_first) begin
            r_ip_dest   <= hdr_ip_dest_i;
            r_ip_src    <= hdr_ip_src_i;
            r_port_dest <= hdr_port_dest_i;
            r_port_src  <= hdr_port_src_i;
         end
      end
   end

   // ---------------- data FIFO: {tdata, tkeep, tlast} ----------------
   logic [36:0]    r_dmem [FIFO_SIZE_DATA];
   logic [DAW-1:0] r_dwp, r_drp;
   logic [DCW-1:0] r_dcnt, r_pkts;
   logic [DCW-1:0] w_dcnt_nxt, w_pkts_nxt;
   logic [36:0]    w_dhead;
   logic           w_drd;

   logic        r_tvld, r_tlast;
   logic [31:0] r_tdata;
   logic [3:0]  r_tkeep;
   logic        w_hpop;

   assign w_dhead = r_dmem[r_drp];
   // only complete packets (tlast already stored) may leave the FIFO
   assign w_drd   = (r_dcnt != '0) && (r_pkts != '0) && (!r_tvld || user_trdy_i);
   assign w_hpop  = r_tvld & user_trdy_i & r_tlast;
   assign w_dcnt_nxt = r_dcnt + DCW'(w_in_acc) - DCW'(w_drd);
   assign w_pkts_nxt = r_pkts + DCW'(w_hpush) - DCW'(w_drd & w_dhead[0]);

   always_ff @(posedge clk) begin
      if (w_in_acc) r_dmem[r_dwp] <= {user_tdata_i, user_tkeep_i, user_tlast_i};
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_dwp   <= '0;
         r_drp   <= '0;
         r_dcnt  <= '0;
         r_pkts  <= '0;
         r_tvld  <= 1'b0;
         r_tlast <= 1'b0;
         r_tdata <= '0;
         r_tkeep <= '0;
      end else begin
         r_dcnt <= w_dcnt_nxt;
         r_pkts <= w_pkts_nxt;
         if (w_in_acc) r_dwp <= r_dwp + 1'b1;
         if (w_drd) begin
            r_drp   <= r_drp + 1'b1;
            r_tvld  <= 1'b1;
            r_tdata <= w_dhead[36:5];
            r_tkeep <= w_dhead[4:1];
            r_tlast <= w_dhead[0];
         end else if (user_trdy_i) begin
            r_tvld <= 1'b0;
         end
      end
   end

   // ---------------- header FIFO, first-word-fall-through via r_head ----------------
   logic [127:0]   r_hmem [FIFO_SIZE_HDR];
   logic [HAW-1:0] r_hwp, r_hrp;
   logic [HCW-1:0] r_hcnt;
   logic           r_hvld;
   logic [127:0]   r_head;
   logic           w_hload, w_hvld_nxt;
   logic [HCW-1:0] w_hcnt_nxt, w_hocc_nxt;

   assign w_hload    = (r_hcnt != '0) && (!r_hvld || w_hpop);
   assign w_hcnt_nxt = r_hcnt + HCW'(w_hpush) - HCW'(w_hload);
   assign w_hvld_nxt = w_hload | (r_hvld & ~w_hpop);
   assign w_hocc_nxt = w_hcnt_nxt + HCW'(w_hvld_nxt);

   always_ff @(posedge clk) begin
      if (w_hpush) r_hmem[r_hwp] <= w_hentry;
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_hwp  <= '0;
         r_hrp  <= '0;
         r_hcnt <= '0;
         r_hvld <= 1'b0;
         r_head <= '0;
         r_trdy <= 1'b0;
      end else begin
         r_hcnt <= w_hcnt_nxt;
         r_hvld <= w_hvld_nxt;
         if (w_hpush) r_hwp <= r_hwp + 1'b1;
         if (w_hload) begin
            r_hrp  <= r_hrp + 1'b1;
            r_head <= r_hmem[r_hrp];
         end
         // registered from next-state occupancy, so it is exact one cycle later
         r_trdy <= (w_dcnt_nxt < DCW'(FIFO_SIZE_DATA)) && (w_hocc_nxt < HCW'(FIFO_SIZE_HDR));
      end
   end

   assign user_trdy_o = r_trdy;
   assign {hdr_ip_dest_o, hdr_ip_src_o, hdr_port_dest_o, hdr_port_src_o,
           user_data_csum_o, user_data_len_o} = r_head;
   assign user_tvld_o  = r_tvld;
   assign user_tlast_o = r_tlast;
   assign user_tdata_o = r_tdata;
   assign user_tkeep_o = r_tkeep;

endmodule

// File: tb/tb_get_stream_len_csum.sv
// Randomized bench for get_stream_len_csum: byte-level reference model, output
// scoreboard, directed corner packets, FIFO fill and mid-packet reset.
module tb_get_stream_len_csum;
   localparam int DD = 128;
   localparam int HD = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] hdr_ip_dest_i, hdr_ip_src_i;
   logic [15:0] hdr_port_dest_i, hdr_port_src_i;
   logic [31:0] user_tdata_i;
   logic        user_tvld_i, user_tlast_i;
   logic [3:0]  user_tkeep_i;
   logic        user_trdy_o;
   logic [31:0] hdr_ip_dest_o, hdr_ip_src_o;
   logic [15:0] hdr_port_dest_o, hdr_port_src_o;
   logic [15:0] user_data_csum_o, user_data_len_o;
   logic [31:0] user_tdata_o;
   logic        user_tvld_o, user_tlast_o;
   logic [3:0]  user_tkeep_o;
   logic        user_trdy_i;

   get_stream_len_csum #(.FIFO_SIZE_DATA(DD), .FIFO_SIZE_HDR(HD)) dut (
      .clk(clk), .reset_n(rst),
      .hdr_ip_dest_i(hdr_ip_dest_i), .hdr_ip_src_i(hdr_ip_src_i),
      .hdr_port_dest_i(hdr_port_dest_i), .hdr_port_src_i(hdr_port_src_i),
      .user_tdata_i(user_tdata_i), .user_tvld_i(user_tvld_i),
      .user_tlast_i(user_tlast_i), .user_tkeep_i(user_tkeep_i),
      .user_trdy_o(user_trdy_o),
      .hdr_ip_dest_o(hdr_ip_dest_o), .hdr_ip_src_o(hdr_ip_src_o),
      .hdr_port_dest_o(hdr_port_dest_o), .hdr_port_src_o(hdr_port_src_o),
      .user_data_csum_o(user_data_csum_o), .user_data_len_o(user_data_len_o),
      .user_tdata_o(user_tdata_o), .user_tvld_o(user_tvld_o),
      .user_tlast_o(user_tlast_o), .user_tkeep_o(user_tkeep_o),
      .user_trdy_i(user_trdy_i)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [36:0]  q_beat [$];
   logic [127:0] q_hdr  [$];
   logic [31:0]  pkt_d  [0:255];
   int           pk_in  = 0;
   int           pk_out = 0;
   int           tr_mode = 0;
   logic [36:0]  eb;

   // byte-level model: length = kept bytes, sum over big-endian 16-bit words
   function automatic logic [31:0] model(input int n, input logic [3:0] lk);
      int unsigned s = 0;
      int unsigned len = 0;
      int pos = 0;
      logic [7:0] by;
      logic kept;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 4; b++) begin
            kept = (i == n - 1) ? lk[3 - b] : 1'b1;
            by   = kept ? pkt_d[i][8*(3-b) +: 8] : 8'h00;
            if (kept) len++;
            s += (pos % 2 == 0) ? 32'(by) * 256 : 32'(by);
            pos++;
         end
      while (s > 65535) s = (s & 65535) + (s >> 16);
      return {s[15:0], len[15:0]};
   endfunction

   function automatic logic [3:0] rand_keep();
      case ($urandom_range(0, 3))
         0: return 4'h8;
         1: return 4'hC;
         2: return 4'hE;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [95:0] rand_h();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      user_trdy_i = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (tr_mode)
            0: user_trdy_i = 1'b1;
            1: user_trdy_i = 1'($urandom_range(0, 1));
            default: user_trdy_i = 1'b0;
         endcase
      end
   end

   // scoreboard: every output handshake is checked against the model queues
   initial forever begin
      @(negedge clk);
      if (rst) pk_out = 0;
      else begin
         if (user_tvld_o) chk("no_early_vld", 128'(pk_in > pk_out), 128'd1);
         if (user_tvld_o && user_trdy_i) begin
            if (q_beat.size() == 0) chk("extra_beat", 128'(q_beat.size()), 128'd1);
            else begin
               eb = q_beat.pop_front();
               chk("beat", 128'({user_tdata_o, user_tkeep_o, user_tlast_o}), 128'(eb));
               chk("hdr", {hdr_ip_dest_o, hdr_ip_src_o, hdr_port_dest_o, hdr_port_src_o,
                           user_data_csum_o, user_data_len_o}, q_hdr[0]);
               if (eb[0]) begin
                  void'(q_hdr.pop_front());
                  pk_out++;
               end
            end
         end
      end
   end

   task automatic wait_acc();
      int t = 0;
      @(negedge clk);
      while (!user_trdy_o && t < 20000) begin
         t++;
         @(negedge clk);
      end
      if (!user_trdy_o) begin
         $display("FAIL in_timeout got=trdy_o 0 exp=1");
         $fatal(1, "input stuck");
      end
      @(posedge clk); #1;
   endtask

   task automatic send_pkt(input logic [95:0] h, input int n, input logic [3:0] lk,
                           input int stop, input bit gaps, input bit use_c,
                           input logic [15:0] c_len, input logic [15:0] c_csum);
      logic [31:0] m;
      if (stop >= n) begin
         m = model(n, lk);
         for (int i = 0; i < n; i++)
            q_beat.push_back({pkt_d[i], (i == n - 1) ? lk : 4'hF, i == n - 1});
         q_hdr.push_back(use_c ? {h, c_csum, c_len} : {h, m});
      end
      for (int i = 0; i < n && i < stop; i++) begin
         if (gaps)
            while ($urandom_range(0, 3) == 0) begin
               user_tvld_i = 1'b0;
               @(posedge clk); #1;
            end
         user_tvld_i  = 1'b1;
         user_tdata_i = pkt_d[i];
         user_tkeep_i = (i == n - 1) ? lk : 4'hF;
         user_tlast_i = (i == n - 1);
         // headers are only meaningful on the first beat; scramble them afterwards
         {hdr_ip_dest_i, hdr_ip_src_i, hdr_port_dest_i, hdr_port_src_i} = (i == 0) ? h : rand_h();
         wait_acc();
      end
      user_tvld_i  = 1'b0;
      user_tlast_i = 1'b0;
      if (stop >= n) pk_in++;
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while (q_beat.size() != 0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      chk(tag, 128'(q_beat.size()), 128'd0);
      @(posedge clk); #1;
   endtask

   task automatic fill_rand(input int n);
      for (int i = 0; i < n; i++) pkt_d[i] = $urandom;
   endtask

   initial begin
      int t;
      int n_fill;
      int n;
      user_tvld_i = 1'b0; user_tlast_i = 1'b0; user_tkeep_i = '0; user_tdata_i = '0;
      {hdr_ip_dest_i, hdr_ip_src_i, hdr_port_dest_i, hdr_port_src_i} = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_trdy", 128'(user_trdy_o), 128'd0);
      chk("rst_vld", 128'(user_tvld_o), 128'd0);
      chk("rst_data", 128'({user_tdata_o, user_tkeep_o, user_tlast_o}), 128'd0);
      chk("rst_hdr", {hdr_ip_dest_o, hdr_ip_src_o, hdr_port_dest_o, hdr_port_src_o,
                      user_data_csum_o, user_data_len_o}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!user_trdy_o && t < 10);
      chk("trdy_rise", 128'(t <= 2), 128'd1);
      @(posedge clk); #1;

      // directed corner packets with hand-computed len/csum
      pkt_d[0] = 32'h01020304;
      send_pkt({32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678}, 1, 4'hF, 1, 0, 1, 16'd4, 16'h0406);
      t = 0;
      do begin @(negedge clk); t++; end while (!user_tvld_o && t < 10);
      chk("vld_latency", 128'(t <= 4), 128'd1);
      @(posedge clk); #1;
      drain("drain_d1");
      pkt_d[0] = 32'hAABBCCDD;
      send_pkt({32'h0A000001, 32'h0A000002, 16'h0050, 16'h1F90}, 1, 4'hE, 1, 0, 1, 16'd3, 16'h76BC);
      pkt_d[0] = 32'hFFFF0001; pkt_d[1] = 32'h00020003;
      send_pkt({32'h0B000001, 32'h0B000002, 16'h0001, 16'h0002}, 2, 4'hF, 2, 0, 1, 16'd8, 16'h0006);
      pkt_d[0] = 32'h00000000; pkt_d[1] = 32'h00000000;
      send_pkt({32'h0C000001, 32'h0C000002, 16'h0003, 16'h0004}, 2, 4'h8, 2, 0, 1, 16'd5, 16'h0000);
      drain("drain_dir");

      // back-to-back packets of 1, 64 and 5 beats under output backpressure
      tr_mode = 1;
      fill_rand(1);  send_pkt(rand_h(), 1,  rand_keep(), 1,  0, 0, 0, 0);
      fill_rand(64); send_pkt(rand_h(), 64, rand_keep(), 64, 0, 0, 0, 0);
      fill_rand(5);  send_pkt(rand_h(), 5,  rand_keep(), 5,  0, 0, 0, 0);
      drain("drain_b2b");

      // output blocked: 1-beat packets until input stalls, then release
      tr_mode = 2;
      @(posedge clk); #1;
      n_fill = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!user_trdy_o) break;
         @(posedge clk); #1;
         fill_rand(1);
         send_pkt(rand_h(), 1, rand_keep(), 1, 0, 0, 0, 0);
         n_fill++;
      end
      chk("fill_count", 128'(n_fill >= 1 && n_fill <= HD), 128'd1);
      @(posedge clk); #1;
      tr_mode = 1;
      drain("drain_fill");

      // random traffic with input gaps; long packets also exercise data-FIFO full
      for (int p = 0; p < 30; p++) begin
         n = $urandom_range(1, 40);
         fill_rand(n);
         send_pkt(rand_h(), n, rand_keep(), n, 1, 0, 0, 0);
      end
      drain("drain_rand");

      // reset with one packet buffered and another half received
      tr_mode = 2;
      @(posedge clk); #1;
      fill_rand(2); send_pkt(rand_h(), 2, rand_keep(), 2, 0, 0, 0, 0);
      fill_rand(6); send_pkt(rand_h(), 6, rand_keep(), 3, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      q_beat.delete(); q_hdr.delete(); pk_in = 0;
      @(negedge clk);
      chk("mid_rst_trdy", 128'(user_trdy_o), 128'd0);
      chk("mid_rst_vld", 128'(user_tvld_o), 128'd0);
      chk("mid_rst_data", 128'({user_tdata_o, user_tkeep_o, user_tlast_o}), 128'd0);
      chk("mid_rst_hdr", {hdr_ip_dest_o, hdr_ip_src_o, hdr_port_dest_o, hdr_port_src_o,
                          user_data_csum_o, user_data_len_o}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      tr_mode = 1;
      fill_rand(4);
      send_pkt(rand_h(), 4, rand_keep(), 4, 0, 0, 0, 0);
      drain("drain_post_rst");
      repeat (10) @(posedge clk);
      chk("no_leftover", 128'(pk_out), 128'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
